// File: rtl/lpf_cfg_rx_if.sv
// Serial configuration link between the CPU-side transmitter and the LPF receiver.
// The transmitter (master) drives the serial lines; the receiver (slave) drives
// the filter controls and status.
interface lpf_cfg_rx_if;
    logic       sclk;
    logic       sen;
    logic       sdi;
    logic       pd;
    logic [7:0] fc;
    logic       upd;
    logic       err;
    logic       busy;

    modport master (
        output sclk, sen, sdi,
        input  pd, fc, upd, err, busy
    );

    modport slave (
        input  sclk, sen, sdi,
        output pd, fc, upd, err, busy
    );
endinterface

// File: rtl/lpf_cfg_rx.sv
// Receive endpoint of the LPF serial configuration link. Oversamples the
// asynchronous sclk/sen/sdi lines, deserializes a 10-bit frame
// (sel, data[7:0] MSB first, even parity) and updates pd or fc on a valid frame.
module lpf_cfg_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FC_RST      = 8'h00,
    parameter logic        PD_RST      = 1'b0
) (
    input logic         clk,
    input logic         rst,
    lpf_cfg_rx_if.slave cfg
);

    typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sen_sync_q, sen_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sclk_hist_q, sen_hist_q;
    logic                   armed_q, armed_d;
    logic                   sclk_s, sen_s, sdi_s;
    logic                   sclk_rise, sen_rise, sen_fall;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] sr_q, sr_d;
    logic       pd_q, pd_d;
    logic [7:0] fc_q, fc_d;
    logic       upd_q, upd_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       frame_ok;

    // Synchronizer chains, edge detection and frame-start arming.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], cfg.sclk};
        sen_sync_d  = {sen_sync_q[SYNC_STAGES-2:0], cfg.sen};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], cfg.sdi};
        // fill_q tracks which chain stages hold real samples rather than reset zeros.
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        sen_s       = sen_sync_q[SYNC_STAGES-1];
        sdi_s       = sdi_sync_q[SYNC_STAGES-1];
        // A frame may only start after sen has genuinely been seen low, so a frame
        // already in progress when reset lifts is ignored.
        armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ~sen_s);
        sclk_rise   = sclk_s & ~sclk_hist_q;
        sen_rise    = sen_s & ~sen_hist_q & armed_q;
        sen_fall    = ~sen_s & sen_hist_q;
    end

    // Register synchronizers, history flops and arming flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            sen_sync_q  <= '0;
            sdi_sync_q  <= '0;
            fill_q      <= '0;
            sclk_hist_q <= 1'b0;
            sen_hist_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sen_sync_q  <= sen_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            fill_q      <= fill_d;
            sclk_hist_q <= sclk_s;
            sen_hist_q  <= sen_s;
            armed_q     <= armed_d;
        end
    end

    // Frame FSM next state: shift bits while sen is high, validate for one cycle after.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        pd_d     = pd_q;
        fc_d     = fc_q;
        upd_d    = 1'b0;
        err_d    = err_q;
        busy_d   = busy_q;
        frame_ok = (cnt_q == 4'd10) && !(^sr_q);
        unique case (state_q)
            StIdle: begin
                if (sen_rise) begin
                    state_d = StShift;
                    cnt_d   = 4'd0;
                    sr_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            StShift: begin
                // A bit coinciding with the sen falling edge is dropped.
                if (sen_fall) begin
                    state_d = StCheck;
                end else if (sclk_rise) begin
                    sr_d = {sr_q[8:0], sdi_s};
                    // Count 11 marks an over-length frame.
                    if (cnt_q != 4'd11) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StCheck: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (frame_ok) begin
                    if (sr_q[9]) begin
                        fc_d = sr_q[8:1];
                    end else begin
                        pd_d = sr_q[1];
                    end
                    upd_d = 1'b1;
                    err_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            sr_q    <= '0;
            pd_q    <= PD_RST;
            fc_q    <= FC_RST;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            pd_q    <= pd_d;
            fc_q    <= fc_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign cfg.pd   = pd_q;
    assign cfg.fc   = fc_q;
    assign cfg.upd  = upd_q;
    assign cfg.err  = err_q;
    assign cfg.busy = busy_q;

endmodule

// File: tb/tb_lpf_cfg_rx.sv
// Bench for lpf_cfg_rx: directed frames from the test plan followed by random
// frames, with a frame-level model checked against the DUT on every clock.
module tb_lpf_cfg_rx;

    localparam int unsigned S = 2;

    logic clk;
    logic rst;
    lpf_cfg_rx_if bus ();

    lpf_cfg_rx #(
        .SYNC_STAGES (S),
        .FC_RST      (8'h00),
        .PD_RST      (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cfg (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state: what the outputs must be on the current cycle.
    logic       exp_pd;
    logic [7:0] exp_fc;
    logic       exp_upd;
    logic       exp_err;
    logic       exp_busy;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        exp_pd   = 1'b0;
        exp_fc   = 8'h00;
        exp_upd  = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;
    endtask

    // Frame bits in transmission order: b[0]=sel, b[1..8]=data MSB first, b[9]=parity.
    function automatic logic [15:0] mk_frame(input logic sel, input logic [7:0] d,
                                             input logic flip, input logic [5:0] extra);
        logic [15:0] b;
        b = '0;
        b[0] = sel;
        for (int j = 0; j < 8; j++) b[1+j] = d[7-j];
        b[9] = sel ^ (^d) ^ flip;
        b[15:10] = extra;
        return b;
    endfunction

    // Apply the frame rules to a received bit list.
    task automatic model_frame(input logic [15:0] b, input int n);
        logic [7:0] d;
        for (int j = 0; j < 8; j++) d[7-j] = b[1+j];
        exp_busy = 1'b0;
        if (n == 10 && (^b[9:0]) == 1'b0) begin
            if (b[0]) exp_fc = d;
            else      exp_pd = d[0];
            exp_upd = 1'b1;
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // Send n bits of b; if abort_at >= 0, pulse rst after that many bits.
    task automatic send_frame(input logic [15:0] b, input int n, input int abort_at);
        int  ph;
        bit  aborted;
        ph = int'($urandom_range(S + 2, S + 5));
        aborted = 1'b0;
        @(negedge clk);
        bus.sen = 1'b1;
        repeat (S + 1) @(posedge clk);
        exp_busy = 1'b1;
        repeat (ph - int'(S)) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                model_reset();
                aborted = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
            bus.sdi = b[i];
            repeat (ph) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (ph) @(negedge clk);
            bus.sclk = 1'b0;
            repeat (ph) @(negedge clk);
        end
        bus.sen = 1'b0;
        if (!aborted) begin
            repeat (S + 2) @(posedge clk);
            model_frame(b, n);
            @(posedge clk);
            exp_upd = 1'b0;
        end
        repeat (ph + 2) @(negedge clk);
    endtask

    // Per-cycle compare of every output against the model.
    initial begin
        while (!check_en) @(posedge clk);
        forever begin
            @(posedge clk);
            #2;
            chk("pd", {7'd0, bus.pd}, {7'd0, exp_pd});
            chk("fc", bus.fc, exp_fc);
            chk("upd", {7'd0, bus.upd}, {7'd0, exp_upd});
            chk("err", {7'd0, bus.err}, {7'd0, exp_err});
            chk("busy", {7'd0, bus.busy}, {7'd0, exp_busy});
        end
    end

    initial begin
        logic [15:0] b;
        int          n;
        int          r;
        rst = 1'b1;
        bus.sclk = 1'b0;
        bus.sen  = 1'b0;
        bus.sdi  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        repeat (8) @(negedge clk);

        // Reset state.
        chk("rst_pd", {7'd0, bus.pd}, 8'h00);
        chk("rst_fc", bus.fc, 8'h00);
        chk("rst_err", {7'd0, bus.err}, 8'h00);
        chk("rst_busy", {7'd0, bus.busy}, 8'h00);

        // FC frame A5.
        b = mk_frame(1'b1, 8'hA5, 1'b0, 6'd0);
        chk("frame_a5_bits", {6'd0, b[9:8]}, 8'h03);
        send_frame(b, 10, -1);
        chk("fc_a5", bus.fc, 8'hA5);
        chk("model_fc_a5", exp_fc, 8'hA5);
        chk("err_a5", {7'd0, bus.err}, 8'h00);

        // PD frames.
        send_frame(mk_frame(1'b0, 8'h01, 1'b0, 6'd0), 10, -1);
        chk("pd_1", {7'd0, bus.pd}, 8'h01);
        chk("fc_kept", bus.fc, 8'hA5);
        send_frame(mk_frame(1'b0, 8'h00, 1'b0, 6'd0), 10, -1);
        chk("pd_0", {7'd0, bus.pd}, 8'h00);

        // Parity error, then recovery.
        send_frame(mk_frame(1'b1, 8'h3C, 1'b1, 6'd0), 10, -1);
        chk("par_fc", bus.fc, 8'hA5);
        chk("par_err", {7'd0, bus.err}, 8'h01);
        send_frame(mk_frame(1'b1, 8'h10, 1'b0, 6'd0), 10, -1);
        chk("fc_10", bus.fc, 8'h10);
        chk("err_clr", {7'd0, bus.err}, 8'h00);

        // Length errors.
        send_frame(mk_frame(1'b1, 8'h55, 1'b0, 6'd0), 9, -1);
        chk("len9_err", {7'd0, bus.err}, 8'h01);
        chk("len9_fc", bus.fc, 8'h10);
        send_frame(mk_frame(1'b1, 8'h66, 1'b0, 6'h3F), 12, -1);
        chk("len12_err", {7'd0, bus.err}, 8'h01);
        chk("len12_fc", bus.fc, 8'h10);

        // sclk activity with sen low.
        for (int i = 0; i < 4; i++) begin
            bus.sdi = i[0];
            repeat (6) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (6) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("idle_fc", bus.fc, 8'h10);

        // Reset mid-frame, then a valid frame.
        send_frame(mk_frame(1'b1, 8'hC3, 1'b0, 6'd0), 10, 5);
        chk("abort_fc", bus.fc, 8'h00);
        chk("abort_busy", {7'd0, bus.busy}, 8'h00);
        send_frame(mk_frame(1'b1, 8'h7E, 1'b0, 6'd0), 10, -1);
        chk("fc_7e", bus.fc, 8'h7E);

        // Random frames.
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0:       n = 9;
                1:       n = 11;
                2:       n = 12;
                3:       n = int'($urandom_range(0, 8));
                default: n = 10;
            endcase
            b = mk_frame(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                         ($urandom_range(0, 6) == 0), 6'($urandom_range(0, 63)));
            send_frame(b, n, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpf_cfg_rx.md
Name: lpf_cfg_rx

Overview:
Receive-side endpoint of the LPF serial configuration link, sitting on the analog-filter side of the die. Deserializes frames driven by the CPU-side serial configuration transmitter. Validates each frame (length and parity) and updates the pd and fc controls that drive the low-pass filter. All serial inputs are asynchronous to clk and are oversampled.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizers on sclk, sen and sdi (minimum 2).
FC_RST, 8'h00, reset value of fc.
PD_RST, 1'b0, reset value of pd.

Ports:
clk   input   1  system clock; one clock domain.
rst   input   1  reset, asynchronous, active-high.
sclk  input   1  serial bit clock from transmitter; sdi is valid at its rising edge.
sen   input   1  frame enable, active-high; frame spans the sen high interval.
sdi   input   1  serial data, MSB first.
pd    output  1  filter power-down control.
fc    output  8  filter cutoff code.
upd   output  1  one-cycle pulse when pd or fc is updated by a valid frame.
err   output  1  frame error flag.
busy  output  1  high while a frame is being received.

Behaviour:
- Reset, asynchronous:
  - pd=PD_RST, fc=FC_RST, upd=0, err=0, busy=0.
  - Synchronizers cleared to 0, bit counter 0, shift register 0, FSM in IDLE.
- Synchronization and edge detection:
  - sclk, sen and sdi each pass through SYNC_STAGES flops, plus one history flop for sclk and sen.
  - Edges are detected as synchronized value != history value.
  - Link constraint: sclk high and low phases, and the sen setup/hold around sclk edges, are each at least SYNC_STAGES+2 clk periods. Behaviour outside this constraint is undefined.
- Frame format, 10 bits:
  - b0 = sel (0 → PD, 1 → FC).
  - b1..b8 = data[7:0], MSB first.
  - b9 = even parity over b0..b8, so the XOR of all 10 bits is 0.
- FSM states:
  - IDLE → SHIFT on sen rising edge. Clears the counter and shift register, sets busy=1.
  - SHIFT:
    - On each sclk rising edge, shift the synchronized sdi into the LSB and increment the counter.
    - The counter saturates at 11; count 11 means more than 10 bits were received.
    - sclk falling edges are ignored.
  - SHIFT → CHECK on sen falling edge.
  - CHECK, exactly one cycle, then always → IDLE with busy=0.
    - If count==10 and parity is OK: when sel=0, pd ← data[0] and fc is unchanged; when sel=1, fc ← data[7:0] and pd is unchanged. upd=1 during the cycle after CHECK. err ← 0.
    - Otherwise (count<10, count>10, or bad parity): pd and fc are unchanged, upd stays 0, err ← 1.
- Latency: pd/fc/upd change on the clk edge ending CHECK, which is 2 clk after the synchronized sen falling edge is detected.
- err is sticky across idle periods. It is cleared only by a subsequent valid frame or by rst.
- Simultaneous events:
  - sclk rising edge detected in the same cycle as the sen falling edge: the bit is discarded and the counter is not incremented.
  - sclk rising edge in the same cycle as the sen rising edge: the bit is discarded.
- sclk activity while in IDLE is ignored; pd and fc are unchanged.
- A sen rising edge while in SHIFT cannot occur, because sen must fall first.
- Reset mid-frame: everything returns to reset values immediately. The rest of the aborted frame is ignored until the next sen rising edge after rst deassertion, even if sen is already high when rst deasserts.

Test Plan:
1. Reset, no activity → pd=0, fc=8'h00, upd=0, err=0, busy=0.
2. FC frame:
   - Stimulus: sel=1, data=8'hA5, parity = 1^(popcount A5=4 → 0) = 1, so bits 1,1010_0101,1 MSB first.
   - Response: fc=8'hA5, pd unchanged, upd single pulse exactly 2 clk after the synchronized sen falling edge, err=0.
3. PD frame:
   - Stimulus: sel=0, data=8'h01, parity=1.
   - Response: pd=1, fc keeps 8'hA5, upd pulse.
   - Follow-up: a PD frame with data=8'h00 gives pd=0.
4. Parity error: FC frame with data=8'h3C and parity bit flipped → fc unchanged, no upd, err=1. A following valid FC frame with 8'h10 → fc=8'h10, err=0.
5. Length errors:
   - 9-bit frame (sen drops early) → err=1, no update.
   - 12-bit frame → err=1, no update.
   - sclk toggled with sen low → no change.
6. Reset mid-frame:
   - Stimulus: assert rst after 5 bits of an FC frame.
   - Response: immediate fc=00, pd=0, busy=0; remaining bits produce no update.
   - Follow-up: the next valid frame with 8'h7E → fc=8'h7E.
